// File: rtl/sound_request_scheduler_pkg.sv
// Sound ids, sound lengths in samples and FSM states shared by the scheduler files.
// Pure definitions; no logic, no latency, no flow control.
package audio_sched_pkg;

    localparam logic [3:0] SND_SHOOT       = 4'd0;
    localparam logic [3:0] SND_FLAP_TOGGLE = 4'd1;
    localparam logic [3:0] SND_PERFECT     = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_PLAYING
    } sched_state_t;

    // Length of each sound in 8 kHz samples; the flap toggle is a 0-length control.
    function automatic logic [15:0] sound_len(input logic [3:0] id);
        case (id)
            4'd0:    return 16'd7009;
            4'd1:    return 16'd0;
            4'd2:    return 16'd12802;
            4'd3:    return 16'd802;
            4'd4:    return 16'd7244;
            4'd5:    return 16'd11037;
            4'd6:    return 16'd1469;
            4'd7:    return 16'd1083;
            4'd8:    return 16'd43480;
            4'd9:    return 16'd27657;
            4'd10:   return 16'd3318;
            4'd11:   return 16'd1631;
            4'd12:   return 16'd29925;
            4'd13:   return 16'd27528;
            4'd14:   return 16'd12031;
            default: return 16'd11036;
        endcase
    endfunction

endpackage

// File: rtl/sound_request_scheduler_if.sv
// Requester and Audio_Control signals of the sound scheduler bundled as one port.
// master = requesters / codec side, slave = scheduler; accept on req_valid & req_ready.
interface sound_request_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_sel;
    logic [5*NREQ-1:0] req_vol;
    logic [NREQ-1:0]   req_ready;
    logic              start;
    logic [3:0]        sel;
    logic [4:0]        vol;
    logic              busy;
    logic [2:0]        owner;

    modport master (
        output req_valid, req_sel, req_vol,
        input  req_ready, start, sel, vol, busy, owner
    );

    modport slave (
        input  req_valid, req_sel, req_vol,
        output req_ready, start, sel, vol, busy, owner
    );
endinterface

// File: rtl/sound_request_scheduler_duration_timer.sv
// Counts down the running sound in samples of TICK_DIV clocks; load restarts it from len.
// running rises the cycle after load; expire is combinational in the cycle remaining hits 0.
module sound_duration_timer #(
    parameter int TICK_DIV = 3125
) (
    input  logic        SYSTEM_Clock,
    input  logic        SYSTEM_Rst,
    input  logic        load,
    input  logic [15:0] len,
    output logic        running,
    output logic        expire
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [15:0]   remaining;

    assign expire = running && (remaining == 16'd0);

    always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
        if (SYSTEM_Rst) begin
            running   <= 1'b0;
            presc     <= '0;
            remaining <= '0;
        end else if (load) begin
            running   <= 1'b1;
            presc     <= '0;
            remaining <= len;
        end else if (expire) begin
            running <= 1'b0;
        end else if (running) begin
            if (presc == PRESC_MAX) begin
                presc     <= '0;
                remaining <= remaining - 16'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sound_request_scheduler.sv
// Fixed-priority scheduler sharing one Audio_Control port between NREQ requesters.
// Accept-to-start 2 cycles; a slot stays not-ready until granted, starts spaced by GAP_CYC.
module sound_request_scheduler
    import audio_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int GAP_CYC  = 16,
    parameter int TICK_DIV = 3125
) (
    input logic SYSTEM_Clock,
    input logic SYSTEM_Rst,
    sound_request_scheduler_if.slave bus
);
    localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC - 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 2);

    sched_state_t    state;
    logic [NREQ-1:0] pending;
    logic [3:0]      slot_sel [NREQ];
    logic [4:0]      slot_vol [NREQ];
    logic [GW-1:0]   gap_cnt;
    logic            start_q;
    logic [3:0]      sel_q;
    logic [4:0]      vol_q;
    logic [2:0]      owner_q;

    logic [NREQ-1:0] eligible;
    logic            grant_vld;
    logic [2:0]      grant_idx;
    logic [3:0]      grant_sel;
    logic [4:0]      grant_vol;
    logic            timer_load;
    logic            timer_running;
    logic            timer_expire;

    // While a sound plays only equal-or-higher priority may cut in; flap toggles always may.
    always_comb begin
        eligible  = '0;
        grant_idx = '0;
        grant_sel = '0;
        grant_vol = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = pending[i] &&
                ((state == ST_IDLE) ||
                 ((state == ST_PLAYING) &&
                  ((3'(i) <= owner_q) || (slot_sel[i] == SND_FLAP_TOGGLE))));
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_idx = 3'(i);
                grant_sel = slot_sel[i];
                grant_vol = slot_vol[i];
            end
        end
    end

    assign grant_vld  = |eligible;
    assign timer_load = grant_vld && (grant_sel != SND_FLAP_TOGGLE);

    sound_duration_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .SYSTEM_Clock (SYSTEM_Clock),
        .SYSTEM_Rst   (SYSTEM_Rst),
        .load         (timer_load),
        .len          (sound_len(grant_sel)),
        .running      (timer_running),
        .expire       (timer_expire)
    );

    always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
        if (SYSTEM_Rst) begin
            state   <= ST_IDLE;
            pending <= '0;
            gap_cnt <= '0;
            start_q <= 1'b0;
            sel_q   <= '0;
            vol_q   <= '0;
            owner_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_sel[i] <= '0;
                slot_vol[i] <= '0;
            end
        end else begin
            start_q <= grant_vld;

            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && !pending[i]) begin
                    pending[i]  <= 1'b1;
                    slot_sel[i] <= bus.req_sel[4*i +: 4];
                    slot_vol[i] <= bus.req_vol[5*i +: 5];
                end else if (grant_vld && (grant_idx == 3'(i))) begin
                    pending[i] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE, ST_PLAYING: begin
                    if (grant_vld) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                        sel_q   <= grant_sel;
                        vol_q   <= grant_vol;
                        if (grant_sel != SND_FLAP_TOGGLE) begin
                            owner_q <= grant_idx;
                        end
                    end else if ((state == ST_PLAYING) && (timer_expire || !timer_running)) begin
                        state <= ST_IDLE;
                    end
                end
                // Start cycle plus GAP_CYC-2 more, so the next start lands GAP_CYC cycles later.
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= (timer_running && !timer_expire) ? ST_PLAYING : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ~pending;
    assign bus.start     = start_q;
    assign bus.sel       = sel_q;
    assign bus.vol       = vol_q;
    assign bus.busy      = timer_running;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_sound_request_scheduler.sv
// Randomized and directed bench for sound_request_scheduler against a time-based reference model.
module tb_sound_request_scheduler;
    localparam int NREQ = 4;
    localparam int GAP  = 8;
    localparam int TD   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sound_request_scheduler_if #(.NREQ(NREQ)) bus();

    sound_request_scheduler #(
        .NREQ     (NREQ),
        .GAP_CYC  (GAP),
        .TICK_DIV (TD)
    ) dut (
        .SYSTEM_Clock (clk),
        .SYSTEM_Rst   (rst),
        .bus          (bus)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int len_tab [16] = '{7009, 0, 12802, 802, 7244, 11037, 1469, 1083,
                         43480, 27657, 3318, 1631, 29925, 27528, 12031, 11036};

    // Reference model: absolute edge times of the last start and of the last busy sample.
    int         e_cnt;
    int         last_grant;
    int         busy_last;
    bit         m_pend [NREQ];
    logic [3:0] m_psel [NREQ];
    logic [4:0] m_pvol [NREQ];
    bit         m_start;
    logic [3:0] m_sel;
    logic [4:0] m_vol;
    logic [2:0] m_owner;
    bit         m_busy;

    task automatic model_reset();
        last_grant = -1000000;
        busy_last  = -1000000;
        for (int i = 0; i < NREQ; i++) begin
            m_pend[i] = 1'b0;
            m_psel[i] = '0;
            m_pvol[i] = '0;
        end
        m_start = 1'b0;
        m_sel   = '0;
        m_vol   = '0;
        m_owner = '0;
        m_busy  = 1'b0;
    endtask

    task automatic model_step();
        bit acc [NREQ];
        int gi;
        bit playing;
        e_cnt++;
        for (int i = 0; i < NREQ; i++) acc[i] = bus.req_valid[i] && !m_pend[i];
        gi = -1;
        if (e_cnt >= last_grant + GAP) begin
            playing = (e_cnt - 1 <= busy_last);
            for (int i = 0; i < NREQ; i++)
                if (gi < 0 && m_pend[i] &&
                    (!playing || i <= int'(m_owner) || m_psel[i] == 4'd1)) gi = i;
        end
        m_start = (gi >= 0);
        if (gi >= 0) begin
            m_pend[gi] = 1'b0;
            m_sel      = m_psel[gi];
            m_vol      = m_pvol[gi];
            last_grant = e_cnt;
            if (m_psel[gi] != 4'd1) begin
                m_owner   = 3'(gi);
                busy_last = e_cnt + len_tab[m_psel[gi]] * TD;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                m_pend[i] = 1'b1;
                m_psel[i] = bus.req_sel[4*i +: 4];
                m_pvol[i] = bus.req_vol[5*i +: 5];
            end
        end
        m_busy = (e_cnt <= busy_last);
    endtask

    initial begin
        e_cnt = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    int st_cyc [$];
    int st_sel [$];
    int tb_cyc = 0;

    // Every-cycle comparison against the model, plus a log of observed starts.
    initial begin
        logic [3:0] exp_rdy;
        forever begin
            @(negedge clk);
            tb_cyc++;
            if (!rst) begin
                exp_rdy = ~{m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
                checks++;
                if (bus.start !== m_start || bus.sel !== m_sel || bus.vol !== m_vol ||
                    bus.busy !== m_busy || bus.req_ready !== exp_rdy ||
                    (m_busy && bus.owner !== m_owner)) begin
                    errors++;
                    $display("FAIL cycle_cmp t=%0t got start=%b sel=%0d vol=%0d busy=%b owner=%0d rdy=%b exp start=%b sel=%0d vol=%0d busy=%b owner=%0d rdy=%b",
                             $time, bus.start, bus.sel, bus.vol, bus.busy, bus.owner, bus.req_ready,
                             m_start, m_sel, m_vol, m_busy, m_owner, exp_rdy);
                end
                if (bus.start) begin
                    st_cyc.push_back(tb_cyc);
                    st_sel.push_back(int'(bus.sel));
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_slot(input int i, input logic [3:0] s, input logic [4:0] v);
        bus.req_sel[4*i +: 4] = s;
        bus.req_vol[5*i +: 5] = v;
    endtask

    task automatic pulse(input logic [3:0] mask);
        @(negedge clk);
        bus.req_valid = mask;
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    task automatic wait_start(input string name, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.start && n < bound);
        chk(name, int'(bus.start), 1);
    endtask

    task automatic wait_busy_low(input string name, input int bound);
        int n = 0;
        while (bus.busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        st_cyc.delete();
        st_sel.delete();
    endtask

    initial begin
        time t0, t1;
        bit  early;
        int  n;
        bus.req_valid = '0;
        bus.req_sel   = '0;
        bus.req_vol   = '0;

        // Reset values
        #2;
        chk("rst_start", int'(bus.start), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready", int'(bus.req_ready), 15);
        chk("rst_sel", int'(bus.sel), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // 1: single request, latency and length
        set_slot(0, 4'd7, 5'd20);
        pulse(4'b0001);
        chk("t1_ready_drop", int'(bus.req_ready[0]), 0);
        chk("t1_no_start_t1", int'(bus.start), 0);
        @(negedge clk);
        chk("t1_start_t2", int'(bus.start), 1);
        chk("t1_sel", int'(bus.sel), 7);
        chk("t1_vol", int'(bus.vol), 20);
        chk("t1_owner", int'(bus.owner), 0);
        t0 = $time;
        wait_busy_low("t1_busy_end", 10000);
        t1 = $time;
        chk_rng("t1_busy_len", int'((t1 - t0) / 10), 4332, 4334);

        // 2: higher priority preempts during PLAYING and reloads the timer
        set_slot(3, 4'd8, 5'd9);
        pulse(4'b1000);
        wait_start("t2_start3", 5);
        chk("t2_owner3", int'(bus.owner), 3);
        tick(20);
        set_slot(1, 4'd6, 5'd3);
        pulse(4'b0010);
        wait_start("t2_start1", 5);
        t0 = $time;
        chk("t2_owner1", int'(bus.owner), 1);
        chk("t2_sel1", int'(bus.sel), 6);
        wait_busy_low("t2_busy_end", 10000);
        t1 = $time;
        chk_rng("t2_reload_len", int'((t1 - t0) / 10), 5876, 5878);

        // 3: lower priority waits for the running sound to end
        do_reset();
        set_slot(0, 4'd3, 5'd31);
        pulse(4'b0001);
        wait_start("t3_start0", 5);
        tick(20);
        set_slot(2, 4'd5, 5'd4);
        pulse(4'b0100);
        early = 1'b0;
        n = 0;
        while (bus.busy && n < 5000) begin
            @(negedge clk);
            n++;
            if (bus.start) early = 1'b1;
        end
        chk("t3_no_early_start", int'(early), 0);
        wait_start("t3_start2", 2);
        chk("t3_sel2", int'(bus.sel), 5);

        // 4: simultaneous requests served in priority order
        do_reset();
        set_slot(0, 4'd3, 5'd1);
        set_slot(1, 4'd7, 5'd2);
        set_slot(2, 4'd10, 5'd3);
        pulse(4'b0111);
        n = 0;
        while (st_cyc.size() < 3 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_three_starts", st_cyc.size(), 3);
        if (st_cyc.size() >= 3) begin
            chk("t4_order0", st_sel[0], 3);
            chk("t4_order1", st_sel[1], 7);
            chk("t4_order2", st_sel[2], 10);
            chk_rng("t4_wait_expiry", st_cyc[1] - st_cyc[0], 3208, 3211);
            chk_rng("t4_spacing12", st_cyc[2] - st_cyc[1], GAP, 100000);
        end

        // 5: flap toggle passes under a higher-priority sound without touching it
        do_reset();
        set_slot(0, 4'd11, 5'd5);
        pulse(4'b0001);
        wait_start("t5_start0", 5);
        t0 = $time;
        tick(10);
        set_slot(2, 4'd1, 5'd7);
        pulse(4'b0100);
        wait_start("t5_flap_start", 5);
        chk("t5_flap_sel", int'(bus.sel), 1);
        chk("t5_flap_vol", int'(bus.vol), 7);
        chk("t5_busy_kept", int'(bus.busy), 1);
        chk("t5_owner_kept", int'(bus.owner), 0);
        wait_busy_low("t5_busy_end", 10000);
        t1 = $time;
        chk_rng("t5_len_kept", int'((t1 - t0) / 10), 6524, 6526);

        // 6: asynchronous reset mid-GAP with pending slots
        do_reset();
        set_slot(0, 4'd3, 5'd11);
        set_slot(1, 4'd6, 5'd12);
        set_slot(2, 4'd7, 5'd13);
        pulse(4'b0111);
        wait_start("t6_start0", 5);
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_start", int'(bus.start), 0);
        chk("t6_rst_sel", int'(bus.sel), 0);
        chk("t6_rst_vol", int'(bus.vol), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_owner", int'(bus.owner), 0);
        chk("t6_rst_ready", int'(bus.req_ready), 15);
        @(negedge clk);
        #2 rst = 1'b0;
        st_cyc.delete();
        st_sel.delete();
        tick(50);
        chk("t6_no_replay", st_cyc.size(), 0);
        set_slot(1, 4'd3, 5'd9);
        pulse(4'b0010);
        wait_start("t6_new_start", 5);
        chk("t6_new_owner", int'(bus.owner), 1);

        // Random traffic checked cycle by cycle against the model
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i] = ($urandom_range(0, 19) == 0);
                if (bus.req_valid[i]) begin
                    case ($urandom_range(0, 3))
                        0:       set_slot(i, 4'd1, 5'($urandom_range(0, 31)));
                        1:       set_slot(i, 4'd3, 5'($urandom_range(0, 31)));
                        2:       set_slot(i, 4'd7, 5'($urandom_range(0, 31)));
                        default: set_slot(i, 4'd11, 5'($urandom_range(0, 31)));
                    endcase
                end
            end
        end
        @(negedge clk);
        bus.req_valid = '0;
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
